// File: rtl/dpram_bank.sv
// Dual-port byte-addressed big-endian RAM: a load/store data port plus an instruction fetch port.
// Define DPRAM_BANK_FWD_EN to merge a same-cycle store into the fetched word (write-first).
module dpram_bank #(
    parameter int RAM_AW     = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [1:0]            d_size_i,
    input  logic                  d_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [31:0]           d_wdata_i,
    output logic [31:0]           d_rdata_o,
    output logic                  d_valid_o,
    output logic                  d_err_o,
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic [31:0]           i_rdata_o,
    output logic                  i_valid_o,
    output logic                  i_err_o
);

    localparam int IW    = RAM_AW - 2;
    localparam int WORDS = 1 << IW;

    typedef logic [IW-1:0] idx_t;

    // Lane k holds byte offset k of every word; lane 0 is the most significant byte.
    logic [7:0] lane_mem [4][WORDS];

    idx_t       d_idx;
    idx_t       i_idx;
    logic [1:0] d_off;
    logic       d_misalign;
    logic       d_store;
    logic [3:0] d_be;
    logic [7:0] d_lane_wdata [4];
    logic [7:0] d_rd_lane    [4];
    logic [7:0] i_rd_lane    [4];
    logic [7:0] d_byte;
    logic [15:0] d_half;
    logic [31:0] d_word;
    logic [31:0] d_load_val;
    logic [31:0] i_word;

    logic        d_valid_q;
    logic        d_err_q;
    logic [31:0] d_rdata_q;
    logic        i_valid_q;
    logic        i_err_q;
    logic [31:0] i_rdata_q;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, d_addr_i[ADDR_WIDTH-1:RAM_AW], i_addr_i[ADDR_WIDTH-1:RAM_AW]};

    assign d_idx = d_addr_i[RAM_AW-1:2];
    assign d_off = d_addr_i[1:0];
    assign i_idx = i_addr_i[RAM_AW-1:2];

    always_comb begin
        d_misalign = 1'b0;
        case (d_size_i)
            2'b00:   d_misalign = 1'b0;
            2'b01:   d_misalign = d_off[0];
            2'b10:   d_misalign = (d_off != 2'b00);
            default: d_misalign = 1'b1;
        endcase
    end

    assign d_store = d_req_i & d_we_i & ~d_misalign;

    // Store byte-enables and per-lane data; aligned accesses never straddle a word.
    always_comb begin
        d_be = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            d_lane_wdata[k] = d_wdata_i[7:0];
        end
        case (d_size_i)
            2'b00: d_be[d_off] = 1'b1;
            2'b01: begin
                d_be[{d_off[1], 1'b0}] = 1'b1;
                d_be[{d_off[1], 1'b1}] = 1'b1;
                d_lane_wdata[0] = d_wdata_i[15:8];
                d_lane_wdata[1] = d_wdata_i[7:0];
                d_lane_wdata[2] = d_wdata_i[15:8];
                d_lane_wdata[3] = d_wdata_i[7:0];
            end
            2'b10: begin
                d_be = 4'b1111;
                for (int k = 0; k < 4; k++) begin
                    d_lane_wdata[k] = d_wdata_i[31-8*k -: 8];
                end
            end
            default: d_be = 4'b0000;
        endcase
        if (!d_store) begin
            d_be = 4'b0000;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            d_rd_lane[k] = lane_mem[k][d_idx];
        end
        d_word = {d_rd_lane[0], d_rd_lane[1], d_rd_lane[2], d_rd_lane[3]};
        d_byte = d_rd_lane[d_off];
        d_half = d_off[1] ? {d_rd_lane[2], d_rd_lane[3]} : {d_rd_lane[0], d_rd_lane[1]};
    end

    always_comb begin
        d_load_val = 32'h0;
        case (d_size_i)
            2'b00:   d_load_val = d_unsigned_i ? {24'h0, d_byte} : {{24{d_byte[7]}}, d_byte};
            2'b01:   d_load_val = d_unsigned_i ? {16'h0, d_half} : {{16{d_half[15]}}, d_half};
            2'b10:   d_load_val = d_word;
            default: d_load_val = 32'h0;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            i_rd_lane[k] = lane_mem[k][i_idx];
`ifdef DPRAM_BANK_FWD_EN
            if (d_be[k] && (d_idx == i_idx)) begin
                i_rd_lane[k] = d_lane_wdata[k];
            end
`endif
        end
        i_word = {i_rd_lane[0], i_rd_lane[1], i_rd_lane[2], i_rd_lane[3]};
    end

    // Memory is never cleared; only writes are gated by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < 4; k++) begin
                if (d_be[k]) begin
                    lane_mem[k][d_idx] <= d_lane_wdata[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            d_valid_q <= 1'b0;
            d_err_q   <= 1'b0;
            d_rdata_q <= 32'h0;
            i_valid_q <= 1'b0;
            i_err_q   <= 1'b0;
            i_rdata_q <= 32'h0;
        end else begin
            d_valid_q <= d_req_i;
            d_err_q   <= d_req_i & d_misalign;
            if (d_req_i) begin
                d_rdata_q <= (d_we_i || d_misalign) ? 32'h0 : d_load_val;
            end
            i_valid_q <= i_req_i;
            i_err_q   <= i_req_i & (i_addr_i[1:0] != 2'b00);
            if (i_req_i) begin
                i_rdata_q <= i_word;
            end
        end
    end

    assign d_valid_o = d_valid_q;
    assign d_err_o   = d_err_q;
    assign d_rdata_o = d_rdata_q;
    assign i_valid_o = i_valid_q;
    assign i_err_o   = i_err_q;
    assign i_rdata_o = i_rdata_q;

    // Backdoor preload; the address wraps modulo the RAM size.
    task writeByte(input logic [ADDR_WIDTH-1:0] byte_addr, input logic [7:0] val);
        lane_mem[byte_addr[1:0]][IW'(byte_addr >> 2)] <= val;
    endtask

endmodule
